// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// Holds the memory-stage result for one cycle, extracts big-endian load data,
// and drives the single register-file write port. Late results from the
// multiply/divide unit (MDU) take the port whenever the pipeline does not
// need it; a small starvation counter asks the hazard unit for a bubble when
// the MDU has been denied for too long. Writes to $zero are always dropped.
module mem_wb_stage #(
  parameter int MDU_WAIT_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  input  logic        mem_mem_to_reg,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_load_type,
  input  logic        mdu_req,
  input  logic [4:0]  mdu_dest,
  input  logic [31:0] mdu_result,
  output logic        mdu_ack,
  output logic        pipe_hold,
  output logic        ld_misalign,
  output logic        RegWrite,
  output logic [4:0]  Write_reg,
  output logic [31:0] Data,
  output logic        wb_fwd_valid
);

  // Load type encodings; anything unlisted behaves as a full word.
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [2:0] CNT_SAT  = 3'd7;
  localparam logic [2:0] WAIT_MAX = 3'(MDU_WAIT_MAX);

  // Stage register
  logic        valid_q,      valid_d;
  logic        reg_write_q,  reg_write_d;
  logic [4:0]  dest_q,       dest_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] load_data_q,  load_data_d;
  logic [2:0]  load_type_q,  load_type_d;
  logic        done_q,       done_d;

  // MDU starvation counter
  logic [2:0]  wait_cnt_q,   wait_cnt_d;

  // Combinational helpers
  logic [1:0]  addr_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] wb_val;
  logic        is_half;
  logic        is_byte;
  logic        misalign;
  logic        pipe_we;

  // Next stage-register contents: flush beats stall, stall holds and
  // remembers that the held instruction already wrote.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    dest_d       = dest_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    load_type_d  = load_type_q;
    done_d       = done_q;
    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall) begin
      done_d = done_q | pipe_we;
    end else begin
      valid_d      = mem_valid;
      reg_write_d  = mem_reg_write;
      dest_d       = mem_dest;
      mem_to_reg_d = mem_mem_to_reg;
      alu_result_d = mem_alu_result;
      load_data_d  = mem_load_data;
      load_type_d  = mem_load_type;
      done_d       = 1'b0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      dest_q       <= 5'd0;
      mem_to_reg_q <= 1'b0;
      alu_result_q <= 32'd0;
      load_data_q  <= 32'd0;
      load_type_q  <= LT_LW;
      done_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      dest_q       <= dest_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      load_type_q  <= load_type_d;
      done_q       <= done_d;
    end
  end

  // Big-endian byte/halfword selection and sign/zero extension.
  always_comb begin
    addr_lo = alu_result_q[1:0];
    case (addr_lo)
      2'd0:    byte_sel = load_data_q[31:24];
      2'd1:    byte_sel = load_data_q[23:16];
      2'd2:    byte_sel = load_data_q[15:8];
      default: byte_sel = load_data_q[7:0];
    endcase
    half_sel = addr_lo[1] ? load_data_q[15:0] : load_data_q[31:16];
    case (load_type_q)
      LT_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_val = {24'd0, byte_sel};
      LT_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_val = {16'd0, half_sel};
      default: load_val = load_data_q;
    endcase
    wb_val = mem_to_reg_q ? load_val : alu_result_q;
  end

  // Alignment check; only a real load in stage can be misaligned.
  always_comb begin
    is_half = (load_type_q == LT_LH) || (load_type_q == LT_LHU);
    is_byte = (load_type_q == LT_LB) || (load_type_q == LT_LBU);
    if (is_byte) begin
      misalign = 1'b0;
    end else if (is_half) begin
      misalign = addr_lo[0];
    end else begin
      misalign = (addr_lo != 2'd0);
    end
    ld_misalign = valid_q & mem_to_reg_q & misalign;
    pipe_we     = valid_q & reg_write_q & (dest_q != 5'd0) & ~done_q & ~ld_misalign;
  end

  // Write-port arbitration: pipeline first, MDU fills idle cycles.
  // The MDU is never granted while reset is asserted.
  always_comb begin
    RegWrite     = 1'b0;
    Write_reg    = 5'd0;
    Data         = 32'd0;
    mdu_ack      = 1'b0;
    wb_fwd_valid = 1'b0;
    if (pipe_we) begin
      RegWrite     = 1'b1;
      Write_reg    = dest_q;
      Data         = wb_val;
      wb_fwd_valid = 1'b1;
    end else if (mdu_req && !rst) begin
      mdu_ack   = 1'b1;
      RegWrite  = (mdu_dest != 5'd0);
      Write_reg = mdu_dest;
      Data      = mdu_result;
    end
  end

  // Count consecutive denied MDU cycles, saturating; any grant or idle clears.
  always_comb begin
    wait_cnt_d = 3'd0;
    if (mdu_req && !mdu_ack) begin
      wait_cnt_d = (wait_cnt_q == CNT_SAT) ? CNT_SAT : wait_cnt_q + 3'd1;
    end
    pipe_hold = (wait_cnt_q >= WAIT_MAX);
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 3'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the write-back stage.
module tb_mem_wb_stage;

  localparam int WAIT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [2:0]  mem_load_type;
  logic        mdu_req;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_result;
  logic        mdu_ack, pipe_hold, ld_misalign, RegWrite, wb_fwd_valid;
  logic [4:0]  Write_reg;
  logic [31:0] Data;

  int checks = 0;
  int errors = 0;

  // Model state: the instruction in stage, whether it already wrote, and
  // the number of consecutive denied MDU cycles.
  bit          m_valid, m_rw, m_m2r, m_done;
  int          m_dest, m_lt, m_cnt;
  logic [31:0] m_alu, m_ld;

  // Expected outputs for the current cycle.
  bit          e_we, e_ack, e_hold, e_mis, e_fwd;
  logic [4:0]  e_wreg;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  mem_wb_stage #(.MDU_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_type(mem_load_type),
    .mdu_req(mdu_req), .mdu_dest(mdu_dest), .mdu_result(mdu_result),
    .mdu_ack(mdu_ack), .pipe_hold(pipe_hold), .ld_misalign(ld_misalign),
    .RegWrite(RegWrite), .Write_reg(Write_reg), .Data(Data),
    .wb_fwd_valid(wb_fwd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input bit v, input bit rw, input int d, input bit m2r,
                         input logic [31:0] alu, input logic [31:0] ld, input int lt);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_dest       = 5'(d);
    mem_mem_to_reg = m2r;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_load_type  = 3'(lt);
  endtask

  // Work out what the write port should show, straight from the stage rules.
  task automatic compute();
    int          lo;
    bit          half, bytel, mis, pwe;
    logic [31:0] v;
    lo    = int'(m_alu[1:0]);
    half  = (m_lt == 1) || (m_lt == 2);
    bytel = (m_lt == 3) || (m_lt == 4);
    mis   = m_valid && m_m2r && (half ? (lo % 2 == 1) : (!bytel && lo != 0));
    pwe   = m_valid && m_rw && (m_dest != 0) && !m_done && !mis;
    if (!m_m2r) begin
      v = m_alu;
    end else if (bytel) begin
      v = (m_ld >> (8 * (3 - lo))) & 32'hFF;
      if (m_lt == 3 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (half) begin
      v = (m_ld >> (16 * (1 - lo / 2))) & 32'hFFFF;
      if (m_lt == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = m_ld;
    end
    e_mis  = mis;
    e_fwd  = pwe;
    e_hold = (m_cnt >= WAIT_MAX);
    e_ack  = 1'b0;
    e_we   = 1'b0;
    e_wreg = 5'd0;
    e_data = 32'd0;
    if (pwe) begin
      e_we   = 1'b1;
      e_wreg = 5'(m_dest);
      e_data = v;
    end else if (mdu_req && !rst) begin
      e_ack  = 1'b1;
      e_we   = (mdu_dest != 5'd0);
      e_wreg = mdu_dest;
      e_data = mdu_result;
    end
  endtask

  task automatic check_all();
    compute();
    chk("RegWrite",     RegWrite,     e_we);
    chk("Write_reg",    Write_reg,    e_wreg);
    chk("Data",         Data,         e_data);
    chk("mdu_ack",      mdu_ack,      e_ack);
    chk("pipe_hold",    pipe_hold,    e_hold);
    chk("ld_misalign",  ld_misalign,  e_mis);
    chk("wb_fwd_valid", wb_fwd_valid, e_fwd);
  endtask

  // Advance the model by one clock using the inputs as they stand now.
  task automatic model_next();
    if (rst) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_cnt   = 0;
    end else begin
      if (mdu_req && !e_ack) m_cnt = (m_cnt >= 7) ? 7 : m_cnt + 1;
      else                   m_cnt = 0;
      if (flush) begin
        m_valid = 1'b0;
        m_done  = 1'b0;
      end else if (stall) begin
        m_done = m_done || e_fwd;
      end else begin
        m_valid = mem_valid;
        m_rw    = mem_reg_write;
        m_dest  = int'(mem_dest);
        m_m2r   = mem_mem_to_reg;
        m_alu   = mem_alu_result;
        m_ld    = mem_load_data;
        m_lt    = int'(mem_load_type);
        m_done  = 1'b0;
      end
    end
  endtask

  // Inputs are changed at the negedge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    check_all();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_mem(0, 0, 0, 0, 32'd0, 32'd0, 0);
    mdu_req = 1'b0; mdu_dest = 5'd0; mdu_result = 32'd0;
    m_valid = 0; m_rw = 0; m_m2r = 0; m_done = 0;
    m_dest = 0; m_lt = 0; m_cnt = 0; m_alu = 0; m_ld = 0;
    e_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state, then idle.
    cycle();
    rst = 1'b0;
    cycle();

    // Load extraction.
    set_mem(1, 1, 5, 1, 32'h0000_1001, 32'h12F4_5678, 3);
    cycle();
    set_mem(1, 1, 6, 1, 32'h0000_1001, 32'h12F4_5678, 4);
    #1 chk("lb_data", Data, 32'hFFFF_FFF4);
    chk("lb_we", RegWrite, 1);
    cycle();
    set_mem(1, 1, 7, 1, 32'h0000_1002, 32'h0000_8001, 1);
    #1 chk("lbu_data", Data, 32'h0000_00F4);
    cycle();
    set_mem(1, 1, 0, 0, 32'h0000_1234, 32'd0, 0);
    #1 chk("lh_data", Data, 32'hFFFF_8001);
    cycle();

    // Register 0 from the pipeline and from the MDU.
    set_mem(0, 0, 0, 0, 32'd0, 32'd0, 0);
    #1 chk("r0_pipe_we", RegWrite, 0);
    cycle();
    mdu_req = 1'b1; mdu_dest = 5'd0; mdu_result = 32'h0000_CAFE;
    #1 chk("r0_mdu_ack", mdu_ack, 1);
    chk("r0_mdu_we", RegWrite, 0);
    cycle();
    mdu_req = 1'b0;

    // Stall: single write, MDU fills a later stall cycle.
    set_mem(1, 1, 8, 0, 32'h0000_0055, 32'd0, 0);
    cycle();
    stall = 1'b1;
    set_mem(0, 0, 0, 0, 32'd0, 32'd0, 0);
    #1 chk("stall1_we", RegWrite, 1);
    chk("stall1_data", Data, 32'h55);
    cycle();
    mdu_req = 1'b1; mdu_dest = 5'd9; mdu_result = 32'hABCD_1234;
    #1 chk("stall2_ack", mdu_ack, 1);
    chk("stall2_wreg", Write_reg, 9);
    cycle();
    mdu_req = 1'b0;
    #1 chk("stall3_we", RegWrite, 0);
    cycle();
    #1 chk("stall4_we", RegWrite, 0);
    cycle();
    stall = 1'b0;

    // Contention: pipeline writes every cycle while the MDU waits.
    set_mem(1, 1, 10, 0, 32'h100, 32'd0, 0);
    cycle();
    mdu_req = 1'b1; mdu_dest = 5'd12; mdu_result = 32'h0000_0077;
    for (int k = 1; k <= 4; k++) begin
      set_mem(k < 4, 1, 10 + k, 0, 32'h100 + 32'(k), 32'd0, 0);
      #1 chk($sformatf("deny%0d_hold", k), pipe_hold, (k == 4));
      chk($sformatf("deny%0d_ack", k), mdu_ack, 0);
      cycle();
    end
    #1 chk("bubble_ack", mdu_ack, 1);
    chk("bubble_wreg", Write_reg, 12);
    cycle();
    mdu_req = 1'b0;
    #1 chk("hold_cleared", pipe_hold, 0);
    cycle();

    // Misaligned loads.
    set_mem(1, 1, 3, 1, 32'h0000_1002, 32'hDEAD_BEEF, 0);
    cycle();
    set_mem(1, 1, 4, 1, 32'h0000_1001, 32'h1122_3344, 1);
    #1 chk("lw_mis", ld_misalign, 1);
    chk("lw_mis_we", RegWrite, 0);
    cycle();
    set_mem(0, 0, 0, 0, 32'd0, 32'd0, 0);
    #1 chk("lh_mis", ld_misalign, 1);
    chk("lh_mis_we", RegWrite, 0);
    cycle();

    // Reset with a write in stage and an MDU request pending.
    set_mem(1, 1, 5, 0, 32'h0000_0099, 32'd0, 0);
    cycle();
    rst = 1'b1;
    mdu_req = 1'b1; mdu_dest = 5'd7; mdu_result = 32'h1357_9BDF;
    set_mem(0, 0, 0, 0, 32'd0, 32'd0, 0);
    cycle();
    #1 chk("rst_we", RegWrite, 0);
    chk("rst_wreg", Write_reg, 0);
    chk("rst_data", Data, 0);
    chk("rst_ack", mdu_ack, 0);
    chk("rst_hold", pipe_hold, 0);
    chk("rst_fwd", wb_fwd_valid, 0);
    cycle();
    rst = 1'b0;
    mdu_req = 1'b0;

    // Flush and stall together load a bubble.
    set_mem(1, 1, 6, 0, 32'h0000_0066, 32'd0, 0);
    cycle();
    flush = 1'b1; stall = 1'b1;
    set_mem(1, 1, 7, 0, 32'h0000_0077, 32'd0, 0);
    cycle();
    flush = 1'b0; stall = 1'b0;
    #1 chk("flush_we", RegWrite, 0);
    chk("flush_fwd", wb_fwd_valid, 0);
    cycle();

    // Random traffic; the MDU holds a request until it is acked.
    e_ack = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom, $urandom, $urandom_range(0, 7));
      if (!mdu_req || e_ack) begin
        mdu_req    = ($urandom_range(0, 2) != 0);
        mdu_dest   = 5'($urandom_range(0, 31));
        mdu_result = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
